// File: rtl/phy_rx_pkg.sv
// -----------------------------------------------------------------------------
// phy_rx_pkg
// Shared definitions for the multi-lane receive deserializer:
//   - state_t     : per-lane alignment state (SEARCH / CHECK / SYNC)
//   - COMMA_DEF   : default alignment/idle symbol
//   - cnt_width() : width of a counter that must hold values 0..max_val
// -----------------------------------------------------------------------------
package phy_rx_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,   // hunting for a comma at any bit position
        ST_CHECK  = 2'd1,   // counting word-aligned commas to qualify lock
        ST_SYNC   = 2'd2    // locked, delivering data words
    } state_t;

    localparam logic [7:0] COMMA_DEF = 8'hBC;

    // Bits needed to represent 0..max_val (never less than one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/phy_rx_deser_n_if.sv
// -----------------------------------------------------------------------------
// phy_rx_deser_n_if
// Serial-in / parallel-out bundle of the deserializer.
//   data_in    : one serial bit per lane, MSB of each word first
//   data_out   : lane i word at [i*WIDTH +: WIDTH], held between updates
//   valid_out  : per-lane one-cycle strobe for a new data word
//   active_out : per-lane lock indication
// Modports: master = serial source / word consumer, slave = deserializer.
// -----------------------------------------------------------------------------
interface phy_rx_deser_n_if #(
    parameter int NUM_LANES = 2,
    parameter int WIDTH     = 8
);
    logic [NUM_LANES-1:0]       data_in;
    logic [NUM_LANES*WIDTH-1:0] data_out;
    logic [NUM_LANES-1:0]       valid_out;
    logic [NUM_LANES-1:0]       active_out;

    modport master (
        output data_in,
        input  data_out,
        input  valid_out,
        input  active_out
    );

    modport slave (
        input  data_in,
        output data_out,
        output valid_out,
        output active_out
    );
endinterface

// File: rtl/phy_rx_lane.sv
// -----------------------------------------------------------------------------
// phy_rx_lane
// Single-lane deserializer: shift register, bit counter, comma-based word
// alignment, lock qualification and loss-of-sync detection.
// Ports:
//   i_clk    : bit-rate clock
//   i_rst_n  : asynchronous active-low reset
//   i_data   : serial input bit, MSB of each word first
//   o_data   : last delivered data word (held)
//   o_valid  : one-cycle strobe when o_data is updated
//   o_active : 1 while the lane is locked
// -----------------------------------------------------------------------------
module phy_rx_lane
    import phy_rx_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] COMMA       = WIDTH'(COMMA_DEF),
    parameter int               SYNC_COMMAS = 4,
    parameter int               MAX_RUN     = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_active
);

    localparam int CNT_W   = cnt_width(WIDTH - 1);
    localparam int COMMA_W = cnt_width(SYNC_COMMAS);
    localparam int RUN_W   = cnt_width(MAX_RUN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_sr;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [COMMA_W-1:0] r_comma_cnt;
    logic [COMMA_W-1:0] w_comma_next;
    logic [RUN_W-1:0]   r_run_cnt;
    logic [RUN_W-1:0]   w_run_next;
    logic [WIDTH-1:0]   r_data;
    logic [WIDTH-1:0]   w_data_next;
    logic               r_valid;
    logic               w_valid_next;

    logic [WIDTH-1:0]   w_nxt;
    logic               w_word_done;
    logic               w_is_comma;

    // Window including the bit being sampled on this edge.
    assign w_nxt       = {r_sr[WIDTH-2:0], i_data};
    assign w_word_done = (r_cnt == CNT_LAST);
    assign w_is_comma  = (w_nxt == COMMA);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_SEARCH;
            r_sr        <= '0;
            r_cnt       <= '0;
            r_comma_cnt <= '0;
            r_run_cnt   <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_sr        <= w_nxt;
            r_cnt       <= w_cnt_next;
            r_comma_cnt <= w_comma_next;
            r_run_cnt   <= w_run_next;
            r_data      <= w_data_next;
            r_valid     <= w_valid_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = w_word_done ? '0 : r_cnt + 1'b1;
        w_comma_next = r_comma_cnt;
        w_run_next   = r_run_cnt;
        w_data_next  = r_data;
        w_valid_next = 1'b0;

        case (r_state)
            ST_SEARCH: begin
                // Bit-granular hunt: a match defines the word boundary, so
                // the counter restarts and the next word ends WIDTH bits later.
                if (w_is_comma) begin
                    w_cnt_next   = '0;
                    w_comma_next = COMMA_W'(1);
                    // Run count restarts here too, so a direct SEARCH->SYNC
                    // entry never inherits the count that caused a loss of sync.
                    w_run_next   = '0;
                    w_state_next = (SYNC_COMMAS == 1) ? ST_SYNC : ST_CHECK;
                end
            end

            ST_CHECK: begin
                if (w_word_done) begin
                    if (w_is_comma) begin
                        if (int'(r_comma_cnt) + 1 == SYNC_COMMAS) begin
                            w_state_next = ST_SYNC;
                            w_comma_next = '0;
                            w_run_next   = '0;
                        end else begin
                            w_comma_next = r_comma_cnt + 1'b1;
                        end
                    end else begin
                        w_state_next = ST_SEARCH;
                        w_comma_next = '0;
                    end
                end
            end

            ST_SYNC: begin
                if (w_word_done) begin
                    if (w_is_comma) begin
                        w_run_next = '0;    // idle symbol, nothing delivered
                    end else begin
                        w_data_next  = w_nxt;
                        w_valid_next = 1'b1;
                        w_run_next   = r_run_cnt + 1'b1;
                        // The word that exceeds the run limit is still
                        // delivered; lock drops on the same edge.
                        if (MAX_RUN != 0 && int'(r_run_cnt) == MAX_RUN) begin
                            w_state_next = ST_SEARCH;
                        end
                    end
                end
            end

            default: begin
                w_state_next = ST_SEARCH;
                w_comma_next = '0;
                w_run_next   = '0;
            end
        endcase
    end

    assign o_data   = r_data;
    assign o_valid  = r_valid;
    assign o_active = (r_state == ST_SYNC);

endmodule

// File: rtl/phy_rx_deser_n.sv
// -----------------------------------------------------------------------------
// phy_rx_deser_n
// Multi-lane receive deserializer. Each lane is an independent phy_rx_lane;
// this level replicates them and packs their words onto the bus.
// Ports:
//   clk_8f : bit-rate clock, all logic on the rising edge
//   reset  : asynchronous active-low reset
//   bus    : phy_rx_deser_n_if slave (data_in, data_out, valid_out, active_out)
// -----------------------------------------------------------------------------
module phy_rx_deser_n
    import phy_rx_pkg::*;
#(
    parameter int               NUM_LANES   = 2,
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] COMMA       = WIDTH'(COMMA_DEF),
    parameter int               SYNC_COMMAS = 4,
    parameter int               MAX_RUN     = 16
) (
    input  logic              clk_8f,
    input  logic              reset,
    phy_rx_deser_n_if.slave   bus
);

    logic [WIDTH-1:0]           w_lane_data [NUM_LANES];
    logic [NUM_LANES-1:0]       w_valid;
    logic [NUM_LANES-1:0]       w_active;
    logic [NUM_LANES*WIDTH-1:0] w_data_packed;

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            phy_rx_lane #(
                .WIDTH       (WIDTH),
                .COMMA       (COMMA),
                .SYNC_COMMAS (SYNC_COMMAS),
                .MAX_RUN     (MAX_RUN)
            ) u_lane (
                .i_clk    (clk_8f),
                .i_rst_n  (reset),
                .i_data   (bus.data_in[gi]),
                .o_data   (w_lane_data[gi]),
                .o_valid  (w_valid[gi]),
                .o_active (w_active[gi])
            );
        end
    endgenerate

    always_comb begin
        w_data_packed = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_data_packed[i*WIDTH +: WIDTH] = w_lane_data[i];
        end
    end

    assign bus.data_out   = w_data_packed;
    assign bus.valid_out  = w_valid;
    assign bus.active_out = w_active;

endmodule
